// File: rtl/rx_framed.sv
// UART receiver: synchronised rx line, mid-bit 3-sample majority vote, optional parity,
// 1/2 stop bits, and a first-word-fall-through word FIFO with sticky overflow.
module rx_framed #(
    parameter int unsigned CLK_BAUD_RATIO = 25,
    parameter int unsigned DATA_SIZE      = 8,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rx_in,
    output logic [DATA_SIZE-1:0]              data_out,
    output logic                              parity_err_out,
    output logic                              frame_err_out,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic                              overflow_out,
    input  logic                              clear_in,
    output logic                              busy_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_out
);

    localparam int unsigned M  = CLK_BAUD_RATIO / 2;
    localparam int unsigned CW = $clog2(CLK_BAUD_RATIO);
    localparam int unsigned BW = $clog2(DATA_SIZE);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WW = DATA_SIZE + 2;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               r_state, w_state_next;
    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic [CW-1:0]        r_baud;
    logic [1:0]           r_smp;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_perr;
    logic                 r_ferr;

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_decide;
    logic                 w_bit;
    logic                 w_push;
    logic [WW-1:0]        w_word;

    assign w_rx_s   = r_sync[1];
    assign w_fall   = r_rx_prev & ~w_rx_s;
    assign w_decide = (r_baud == CW'(M + 1));
    assign w_bit    = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);
    assign w_word   = {r_perr, r_ferr | ~w_bit, r_data};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx_in};
            r_rx_prev <= w_rx_s;
        end
    end

    // Bit timer free-runs while a frame is in progress and is held at zero in idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_baud <= '0;
            r_smp  <= 2'b11;
        end else begin
            if (r_state == StIdle || r_baud == CW'(CLK_BAUD_RATIO - 1)) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_baud == CW'(M - 1)) r_smp[0] <= w_rx_s;
            if (r_baud == CW'(M))     r_smp[1] <= w_rx_s;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_fall) w_state_next = StStart;
            end
            StStart: begin
                if (w_decide) w_state_next = w_bit ? StIdle : StData;
            end
            StData: begin
                if (w_decide && r_bit_cnt == BW'(DATA_SIZE - 1)) begin
                    w_state_next = (PARITY != 0) ? StParity : StStop;
                end
            end
            StParity: begin
                if (w_decide) w_state_next = StStop;
            end
            StStop: begin
                // Leave at mid stop bit so the following start edge is not missed.
                if (w_decide && r_stop_cnt == 1'(STOP_BITS - 1)) begin
                    w_push       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else if (w_decide) begin
            case (r_state)
                StStart: begin
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= 1'b0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                end
                StData: begin
                    r_data    <= {w_bit, r_data[DATA_SIZE-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                StParity: begin
                    r_perr <= ((^r_data) ^ w_bit) != (PARITY == 2);
                end
                StStop: begin
                    r_ferr     <= r_ferr | ~w_bit;
                    r_stop_cnt <= r_stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [WW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [NW-1:0] r_count;
    logic          r_ovf;
    logic          w_full, w_valid, w_pop, w_wr;

    assign w_full  = (r_count == NW'(FIFO_DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & ready_in;
    // A pop in the same cycle frees the slot for an incoming word.
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_in) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (clear_in) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign data_out       = r_mem[r_rd_ptr][DATA_SIZE-1:0];
    assign frame_err_out  = w_valid & r_mem[r_rd_ptr][DATA_SIZE];
    assign parity_err_out = w_valid & r_mem[r_rd_ptr][DATA_SIZE+1];
    assign valid_out      = w_valid;
    assign overflow_out   = r_ovf;
    assign busy_out       = (r_state != StIdle);
    assign count_out      = r_count;

endmodule

// File: tb/tb_rx_framed.sv
// Directed bench for rx_framed: 8N1, 8E1 and 8O1 instances at 25 clocks per bit.
module tb_rx_framed;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic rx0 = 1'b1, rx_e = 1'b1, rx_o = 1'b1;
    logic rdy0 = 1'b0, rdy_e = 1'b0, rdy_o = 1'b0;

    logic [7:0] data0, data_e, data_o;
    logic       perr0, perr_e, perr_o;
    logic       ferr0, ferr_e, ferr_o;
    logic       val0, val_e, val_o;
    logic       ovf0, ovf_e, ovf_o;
    logic       busy0, busy_e, busy_o;
    logic [2:0] cnt0, cnt_e, cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rx_framed #(.PARITY(0)) u_dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .rx_in(rx0), .data_out(data0),
        .parity_err_out(perr0), .frame_err_out(ferr0), .valid_out(val0), .ready_in(rdy0),
        .overflow_out(ovf0), .clear_in(clear), .busy_out(busy0), .count_out(cnt0)
    );

    rx_framed #(.PARITY(1)) u_dut_e (
        .clk_in(clk), .rst_n_in(rst_n), .rx_in(rx_e), .data_out(data_e),
        .parity_err_out(perr_e), .frame_err_out(ferr_e), .valid_out(val_e), .ready_in(rdy_e),
        .overflow_out(ovf_e), .clear_in(clear), .busy_out(busy_e), .count_out(cnt_e)
    );

    rx_framed #(.PARITY(2)) u_dut_o (
        .clk_in(clk), .rst_n_in(rst_n), .rx_in(rx_o), .data_out(data_o),
        .parity_err_out(perr_o), .frame_err_out(ferr_o), .valid_out(val_o), .ready_in(rdy_o),
        .overflow_out(ovf_o), .clear_in(clear), .busy_out(busy_o), .count_out(cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx0  = v;
            1:       rx_e = v;
            default: rx_o = v;
        endcase
    endtask

    // Drive n line bits LSB first, one bit period each, starting at a negedge.
    task automatic send_seq(input int sel, input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, seq[i]);
            repeat (25) @(negedge clk);
        end
    endtask

    task automatic pop(input int sel);
        case (sel)
            0:       rdy0  = 1'b1;
            1:       rdy_e = 1'b1;
            default: rdy_o = 1'b1;
        endcase
        @(negedge clk);
        rdy0  = 1'b0;
        rdy_e = 1'b0;
        rdy_o = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", val0, 0);
        check("rst_count", cnt0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_perr", perr0, 0);
        check("rst_ferr", ferr0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 basic word
        send_seq(0, {1'b1, 8'hA5, 1'b0}, 10);
        repeat (5) @(negedge clk);
        check("a5_valid", val0, 1);
        check("a5_data", data0, 8'hA5);
        check("a5_perr", perr0, 0);
        check("a5_ferr", ferr0, 0);
        check("a5_count", cnt0, 1);
        pop(0);
        check("a5_count_after_pop", cnt0, 0);
        check("a5_busy_after_pop", busy0, 0);

        // Start glitch of 4 clocks
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        check("glitch_busy_seen", busy0, 1);
        repeat (25) @(negedge clk);
        check("glitch_busy_gone", busy0, 0);
        check("glitch_no_push", cnt0, 0);
        repeat (30) @(negedge clk);

        // Parity: 0x3C has four ones
        send_seq(1, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        repeat (5) @(negedge clk);
        check("even_p1_data", data_e, 8'h3C);
        check("even_p1_perr", perr_e, 1);
        pop(1);
        send_seq(1, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        repeat (5) @(negedge clk);
        check("even_p0_data", data_e, 8'h3C);
        check("even_p0_perr", perr_e, 0);
        pop(1);
        send_seq(2, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        repeat (5) @(negedge clk);
        check("odd_p1_data", data_o, 8'h3C);
        check("odd_p1_perr", perr_o, 0);
        pop(2);
        send_seq(2, {1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        repeat (5) @(negedge clk);
        check("odd_p0_perr", perr_o, 1);
        check("odd_p0_ferr", ferr_o, 0);
        pop(2);
        check("odd_empty", cnt_o, 0);

        // Low stop bit
        send_seq(0, {1'b0, 8'h55, 1'b0}, 10);
        rx0 = 1'b1;
        repeat (30) @(negedge clk);
        check("ferr_data", data0, 8'h55);
        check("ferr_flag", ferr0, 1);
        check("ferr_count", cnt0, 1);
        pop(0);

        // Break: line low for three frame times
        rx0 = 1'b0;
        repeat (750) @(negedge clk);
        rx0 = 1'b1;
        repeat (30) @(negedge clk);
        check("break_count", cnt0, 1);
        check("break_data", data0, 8'h00);
        check("break_ferr", ferr0, 1);
        pop(0);
        check("break_empty", cnt0, 0);

        // Overflow: five back-to-back words into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) send_seq(0, {1'b1, 8'(i), 1'b0}, 10);
        repeat (5) @(negedge clk);
        check("ovf_count", cnt0, 4);
        check("ovf_flag", ovf0, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_pop%0d", i), data0, i);
            pop(0);
        end
        check("ovf_drained", cnt0, 0);
        check("ovf_sticky", ovf0, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("ovf_cleared", ovf0, 0);

        // Full FIFO, pop in the same cycle the 5th word lands (242 clocks after its start bit)
        for (int i = 1; i <= 4; i++) send_seq(0, {1'b1, 8'(i), 1'b0}, 10);
        fork
            send_seq(0, {1'b1, 8'h05, 1'b0}, 10);
            begin
                repeat (241) @(negedge clk);
                rdy0 = 1'b1;
                @(negedge clk);
                rdy0 = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("fullpop_count", cnt0, 4);
        check("fullpop_ovf", ovf0, 0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("fullpop_pop%0d", i), data0, i);
            pop(0);
        end

        // Reset in the middle of a data bit
        send_seq(0, {1'b1, 8'h33, 1'b0}, 10);
        repeat (5) @(negedge clk);
        check("pre_rst_count", cnt0, 1);
        send_seq(0, 16'b10, 2);
        rx0 = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_frame_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy0, 0);
        check("midrst_valid", val0, 0);
        check("midrst_count", cnt0, 0);
        check("midrst_ferr", ferr0, 0);
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("postrst_idle", busy0, 0);
        send_seq(0, {1'b1, 8'h81, 1'b0}, 10);
        repeat (5) @(negedge clk);
        check("postrst_count", cnt0, 1);
        check("postrst_data", data0, 8'h81);
        check("postrst_ferr", ferr0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
